// File: rtl/load_store_unit_if.sv
// Request, memory-side and writeback bundle for load_store_unit.
//   req_*  : EX/MEM handshake (valid/ready, op, address, store data, rd)
//   mem_*  : drive to / read data from bram_addresser_with_brams
//   wb_*   : registered result toward the MEM/WB register
// slave is the unit's view; master is the view of whatever drives it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [4:0]  mem_access_code;
  logic [31:0] mem_address;
  logic [31:0] mem_data_to_store;
  logic [31:0] mem_read_data;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_fault;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd, mem_read_data,
    output req_ready, mem_access_code, mem_address, mem_data_to_store,
           wb_valid, wb_we, wb_rd, wb_data, wb_fault
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd, mem_read_data,
    input  req_ready, mem_access_code, mem_address, mem_data_to_store,
           wb_valid, wb_we, wb_rd, wb_data, wb_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller sitting in front of bram_addresser_with_brams.
// Accepts one request per handshake, drives access code / address / store data for one
// ACCESS cycle (the BRAM works on the negedge inside it), then presents an aligned and
// extended result for one DONE cycle. Illegal ops and out-of-range accesses skip ACCESS.
// Ports:
//   CLOCK_50 : clock, all state on posedge
//   resetn   : synchronous active-low reset
//   bus      : load_store_unit_if slave (request, memory and writeback signals)
module load_store_unit #(
  parameter int unsigned ADDR_BITS = 18
) (
  input logic               CLOCK_50,
  input logic               resetn,
  load_store_unit_if.slave  bus
);

  localparam logic [3:0] OpLb  = 4'b0000;
  localparam logic [3:0] OpLh  = 4'b0001;
  localparam logic [3:0] OpLw  = 4'b0010;
  localparam logic [3:0] OpLbu = 4'b0100;
  localparam logic [3:0] OpLhu = 4'b0101;
  localparam logic [3:0] OpSb  = 4'b1000;
  localparam logic [3:0] OpSh  = 4'b1001;
  localparam logic [3:0] OpSw  = 4'b1010;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q;
  logic [3:0]  op_q;
  logic [4:0]  rd_q;
  logic [4:0]  code_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic        wb_valid_q;
  logic        wb_we_q;
  logic        wb_fault_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  // Request decode
  logic               op_legal;
  logic [1:0]         size_m1;
  logic [4:0]         acc_code;
  logic [31:0]        st_data;
  logic [ADDR_BITS:0] end_addr;
  logic               req_fault;

  always_comb begin
    op_legal = 1'b1;
    size_m1  = 2'd0;
    acc_code = 5'b0_0000;
    st_data  = 32'h0;
    case (bus.req_op)
      OpLb, OpLbu: begin size_m1 = 2'd0; acc_code = 5'b0_1111; end
      OpLh, OpLhu: begin size_m1 = 2'd1; acc_code = 5'b0_1111; end
      OpLw:        begin size_m1 = 2'd3; acc_code = 5'b0_1111; end
      OpSb: begin
        size_m1  = 2'd0;
        acc_code = 5'b1_1000;
        st_data  = {bus.req_wdata[7:0], 24'h0};
      end
      OpSh: begin
        size_m1  = 2'd1;
        acc_code = 5'b1_1100;
        st_data  = {bus.req_wdata[15:0], 16'h0};
      end
      OpSw: begin
        size_m1  = 2'd3;
        acc_code = 5'b1_1111;
        st_data  = bus.req_wdata;
      end
      default: op_legal = 1'b0;
    endcase
    // Carry out of the low ADDR_BITS means the last byte lies past the top of memory
    end_addr  = {1'b0, bus.req_addr[ADDR_BITS-1:0]} + {{(ADDR_BITS-1){1'b0}}, size_m1};
    req_fault = !op_legal || (bus.req_addr[31:ADDR_BITS] != '0) || end_addr[ADDR_BITS];
  end

  // Lane 0 ([31:24]) holds the byte at the access address
  logic [31:0] load_ext;
  always_comb begin
    case (op_q)
      OpLb:    load_ext = {{24{bus.mem_read_data[31]}}, bus.mem_read_data[31:24]};
      OpLbu:   load_ext = {24'h0, bus.mem_read_data[31:24]};
      OpLh:    load_ext = {{16{bus.mem_read_data[31]}}, bus.mem_read_data[31:16]};
      OpLhu:   load_ext = {16'h0, bus.mem_read_data[31:16]};
      default: load_ext = bus.mem_read_data;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q    <= StIdle;
      op_q       <= 4'h0;
      rd_q       <= 5'h0;
      code_q     <= 5'h0;
      addr_q     <= 32'h0;
      sdata_q    <= 32'h0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_fault_q <= 1'b0;
      wb_rd_q    <= 5'h0;
      wb_data_q  <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            op_q   <= bus.req_op;
            rd_q   <= bus.req_rd;
            addr_q <= bus.req_addr;
            if (req_fault) begin
              // Straight to DONE; code_q stays 0 so the memory never sees a write
              state_q    <= StDone;
              wb_valid_q <= 1'b1;
              wb_fault_q <= 1'b1;
              wb_we_q    <= 1'b0;
              wb_rd_q    <= bus.req_rd;
              wb_data_q  <= 32'h0;
            end else begin
              state_q <= StAccess;
              code_q  <= acc_code;
              sdata_q <= st_data;
            end
          end
        end
        StAccess: begin
          state_q    <= StDone;
          code_q     <= 5'h0;
          wb_valid_q <= 1'b1;
          wb_fault_q <= 1'b0;
          wb_rd_q    <= rd_q;
          wb_we_q    <= !op_q[3];
          wb_data_q  <= op_q[3] ? 32'h0 : load_ext;
        end
        StDone: begin
          state_q    <= StIdle;
          wb_valid_q <= 1'b0;
          wb_we_q    <= 1'b0;
          wb_fault_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready         = (state_q == StIdle);
  assign bus.mem_access_code   = code_q;
  assign bus.mem_address       = addr_q;
  assign bus.mem_data_to_store = sdata_q;
  assign bus.wb_valid          = wb_valid_q;
  assign bus.wb_we             = wb_we_q;
  assign bus.wb_rd             = wb_rd_q;
  assign bus.wb_data           = wb_data_q;
  assign bus.wb_fault          = wb_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural byte-lane BRAM behind it.
module tb_load_store_unit;

  localparam logic [3:0] LB  = 4'b0000;
  localparam logic [3:0] LH  = 4'b0001;
  localparam logic [3:0] LW  = 4'b0010;
  localparam logic [3:0] LBU = 4'b0100;
  localparam logic [3:0] LHU = 4'b0101;
  localparam logic [3:0] SB  = 4'b1000;
  localparam logic [3:0] SH  = 4'b1001;
  localparam logic [3:0] SW  = 4'b1010;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   pulses = 0;

  always #5 clk = ~clk;

  load_store_unit_if lsu_if ();

  load_store_unit #(.ADDR_BITS(18)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (lsu_if)
  );

  // Addresser + BRAM model: lane i ([31-8i -: 8]) maps to byte address addr+i,
  // enable bit (3-i) gates that lane; read and write both on the negedge.
  logic [7:0]  mem [0:262143] = '{default: 8'h00};
  logic [17:0] ma;
  always @(negedge clk) begin
    ma = lsu_if.mem_address[17:0];
    lsu_if.mem_read_data <= {mem[ma], mem[ma + 18'd1], mem[ma + 18'd2], mem[ma + 18'd3]};
    if (lsu_if.mem_access_code[4]) begin
      if (lsu_if.mem_access_code[3]) mem[ma]         <= lsu_if.mem_data_to_store[31:24];
      if (lsu_if.mem_access_code[2]) mem[ma + 18'd1] <= lsu_if.mem_data_to_store[23:16];
      if (lsu_if.mem_access_code[1]) mem[ma + 18'd2] <= lsu_if.mem_data_to_store[15:8];
      if (lsu_if.mem_access_code[0]) mem[ma + 18'd3] <= lsu_if.mem_data_to_store[7:0];
    end
  end

  always @(posedge clk) if (lsu_if.wb_valid === 1'b1) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a posedge with the unit idle; returns #1 after the accepting edge.
  task automatic accept(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
    lsu_if.req_valid = 1'b1;
    lsu_if.req_op    = op;
    lsu_if.req_addr  = addr;
    lsu_if.req_wdata = wdata;
    lsu_if.req_rd    = rd;
    @(posedge clk); #1;
    lsu_if.req_valid = 1'b0;
  endtask

  task automatic run_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] exp_code,
                           input logic [31:0] exp_data);
    accept(op, addr, wdata, 5'd0);
    chk({tag, " code"}, 32'(lsu_if.mem_access_code), 32'(exp_code));
    chk({tag, " addr"}, lsu_if.mem_address, addr);
    chk({tag, " sdata"}, lsu_if.mem_data_to_store, exp_data);
    chk({tag, " access no wb"}, 32'(lsu_if.wb_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, " wb"}, {27'd0, lsu_if.wb_valid, lsu_if.wb_we, lsu_if.wb_fault,
                       lsu_if.mem_access_code[4], lsu_if.req_ready}, 32'b10000);
    chk({tag, " wb_data"}, lsu_if.wb_data, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] exp);
    accept(op, addr, 32'hCAFE_F00D, rd);
    chk({tag, " code"}, 32'(lsu_if.mem_access_code), 32'h0F);
    chk({tag, " addr"}, lsu_if.mem_address, addr);
    chk({tag, " access no wb"}, 32'(lsu_if.wb_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, " wb"}, {27'd0, lsu_if.wb_valid, lsu_if.wb_we, lsu_if.wb_fault,
                       lsu_if.mem_access_code[4], lsu_if.req_ready}, 32'b11000);
    chk({tag, " wb_rd"}, 32'(lsu_if.wb_rd), 32'(rd));
    chk({tag, " wb_data"}, lsu_if.wb_data, exp);
    @(posedge clk); #1;
    chk({tag, " idle"}, {30'd0, lsu_if.wb_valid, lsu_if.req_ready}, 32'b01);
  endtask

  task automatic run_fault(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [4:0] rd);
    accept(op, addr, 32'hFFFF_FFFF, rd);
    // One-cycle latency: result already present after the accepting edge
    chk({tag, " wb"}, {27'd0, lsu_if.wb_valid, lsu_if.wb_we, lsu_if.wb_fault,
                       lsu_if.mem_access_code[4], lsu_if.req_ready}, 32'b10100);
    chk({tag, " code"}, 32'(lsu_if.mem_access_code), 32'h0);
    chk({tag, " wb_data"}, lsu_if.wb_data, 32'h0);
    chk({tag, " wb_rd"}, 32'(lsu_if.wb_rd), 32'(rd));
    @(posedge clk); #1;
    chk({tag, " idle"}, {30'd0, lsu_if.wb_valid, lsu_if.req_ready}, 32'b01);
  endtask

  logic [3:0]  b_op   [3] = '{LW, LBU, LH};
  logic [31:0] b_addr [3] = '{32'h100, 32'h201, 32'h304};
  logic [4:0]  b_rd   [3] = '{5'd7, 5'd8, 5'd9};
  logic [31:0] b_exp  [3] = '{32'hDEADBEEF, 32'h000000FF, 32'h00005A77};

  initial begin
    int p0;
    lsu_if.req_valid = 1'b0;
    lsu_if.req_op    = 4'h0;
    lsu_if.req_addr  = 32'h0;
    lsu_if.req_wdata = 32'h0;
    lsu_if.req_rd    = 5'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {lsu_if.mem_access_code, lsu_if.wb_valid, lsu_if.wb_we,
                          lsu_if.wb_fault, lsu_if.wb_rd, lsu_if.req_ready}, 32'h1);
    chk("reset addr", lsu_if.mem_address, 32'h0);
    chk("reset sdata", lsu_if.mem_data_to_store, 32'h0);
    chk("reset wb_data", lsu_if.wb_data, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_store("SW 100", SW, 32'h100, 32'hDEADBEEF, 5'h1F, 32'hDEADBEEF);
    run_load("LW 100", LW, 32'h100, 5'd5, 32'hDEADBEEF);

    run_store("SW 200", SW, 32'h200, 32'h80FF7F01, 5'h1F, 32'h80FF7F01);
    run_load("LB 201", LB, 32'h201, 5'd1, 32'hFFFFFFFF);
    run_load("LBU 201", LBU, 32'h201, 5'd2, 32'h000000FF);
    run_load("LH 202", LH, 32'h202, 5'd3, 32'h00007F01);
    run_load("LHU 200", LHU, 32'h200, 5'd4, 32'h000080FF);

    run_store("SW 300", SW, 32'h300, 32'h0, 5'h1F, 32'h0);
    run_store("SW 304", SW, 32'h304, 32'h0, 5'h1F, 32'h0);
    run_store("SH 303", SH, 32'h303, 32'h0000A55A, 5'h1C, 32'hA55A0000);
    run_load("LW 300", LW, 32'h300, 5'd6, 32'h000000A5);
    run_load("LW 304", LW, 32'h304, 5'd10, 32'h5A000000);
    run_store("SB 305", SB, 32'h305, 32'h12345677, 5'h18, 32'h77000000);
    run_load("LW 304b", LW, 32'h304, 5'd11, 32'h5A770000);

    run_fault("LW 3FFFD", LW, 32'h3FFFD, 5'd12);
    run_fault("op 0011", 4'b0011, 32'h100, 5'd13);
    run_fault("LB 40000", LB, 32'h40000, 5'd14);
    run_fault("SH 3FFFF", SH, 32'h3FFFF, 5'd15);
    run_load("LW 3FFFC", LW, 32'h3FFFC, 5'd16, 32'h0);
    run_store("SB 3FFFF", SB, 32'h3FFFF, 32'h000000C3, 5'h18, 32'hC3000000);
    run_load("LBU 3FFFF", LBU, 32'h3FFFF, 5'd17, 32'h000000C3);
    run_load("LW 100 intact", LW, 32'h100, 5'd18, 32'hDEADBEEF);

    // Back-to-back: req_valid never drops; next request is presented right after acceptance
    p0 = pulses;
    lsu_if.req_valid = 1'b1;
    lsu_if.req_op    = b_op[0];
    lsu_if.req_addr  = b_addr[0];
    lsu_if.req_rd    = b_rd[0];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("b2b access ready", {30'd0, lsu_if.req_ready, lsu_if.wb_valid}, 32'b00);
      if (k < 2) begin
        lsu_if.req_op   = b_op[k+1];
        lsu_if.req_addr = b_addr[k+1];
        lsu_if.req_rd   = b_rd[k+1];
      end else begin
        lsu_if.req_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("b2b done", {29'd0, lsu_if.req_ready, lsu_if.wb_valid, lsu_if.wb_we}, 32'b011);
      chk("b2b rd", 32'(lsu_if.wb_rd), 32'(b_rd[k]));
      chk("b2b data", lsu_if.wb_data, b_exp[k]);
      @(posedge clk); #1;
      chk("b2b idle", {30'd0, lsu_if.req_ready, lsu_if.wb_valid}, 32'b10);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("b2b pulse count", 32'(pulses - p0), 32'd3);

    // Reset held for two cycles while a store is in ACCESS
    accept(SW, 32'h400, 32'h11111111, 5'd3);
    chk("pre-reset access", 32'(lsu_if.mem_access_code), 32'h1F);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid reset outputs", {lsu_if.mem_access_code, lsu_if.wb_valid, lsu_if.wb_we,
                              lsu_if.wb_fault, lsu_if.wb_rd, lsu_if.req_ready}, 32'h1);
    chk("mid reset addr", lsu_if.mem_address, 32'h0);
    chk("mid reset sdata", lsu_if.mem_data_to_store, 32'h0);
    chk("mid reset wb_data", lsu_if.wb_data, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post reset idle", {30'd0, lsu_if.req_ready, lsu_if.wb_valid}, 32'b10);
    run_load("LW after reset", LW, 32'h100, 5'd19, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage controller between the execute/memory pipeline register and bram_addresser_with_brams.
- Accepts one load/store request per handshake and decodes it into memory_access_code, data_to_store and memory_address for the addresser.
- Waits out the negedge-clocked BRAM read, then aligns and extends load data.
- Presents a registered result to the memory/writeback register, with range and opcode fault checking.

Parameters:
ADDR_BITS, 18, byte-address width of data memory (valid addresses 0 .. 2^ADDR_BITS-1)

Ports:
CLOCK_50  input  1  system clock; all state updates on posedge
resetn  input  1  synchronous, active-low reset, sampled on posedge CLOCK_50
req_valid  input  1  EX/MEM holds a memory instruction
req_ready  output  1  unit can accept a request this cycle
req_op  input  4  0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; others illegal
req_addr  input  32  effective byte address
req_wdata  input  32  rs2 value for stores
req_rd  input  5  destination register for loads
mem_access_code  output  5  to addresser memory_access_code: [4]=store, [3:0]=byte enables
mem_address  output  32  to addresser memory_address
mem_data_to_store  output  32  to addresser data_to_store
mem_read_data  input  32  from addresser writeback_register_data; [31:24] is the byte at mem_address
wb_valid  output  1  one-cycle pulse: result present
wb_we  output  1  register write requested (loads only)
wb_rd  output  5  destination register
wb_data  output  32  aligned, extended load data
wb_fault  output  1  request was illegal or out of range; no memory side effect

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; mem_access_code=0, mem_address=0, mem_data_to_store=0; wb_valid=0, wb_we=0, wb_fault=0, wb_rd=0, wb_data=0.
  - Reset overrides any in-flight access; a store in ACCESS whose cycle is cut by reset may or may not have written.
- FSM states: IDLE, ACCESS, DONE.
  - req_ready=1 only in IDLE.
  - IDLE: req_valid=1 at posedge registers op/addr/wdata/rd; next state is ACCESS, or DONE directly if faulted.
  - ACCESS: lasts one cycle; always goes to DONE.
  - DONE: lasts one cycle; always goes to IDLE.
- Encoding, registered at acceptance and held constant through ACCESS:
  - SB: code 1_1000, data {wdata[7:0],24'h0}.
  - SH: code 1_1100, data {wdata[15:0],16'h0}.
  - SW: code 1_1111, data wdata.
  - Loads: code 0_1111, data 0.
  - mem_address is the request address.
- Outside ACCESS, mem_access_code[4]=0, so no spurious writes occur.
- Load timing:
  - Address is driven in ACCESS; the BRAM samples on the negedge inside ACCESS.
  - The posedge ending ACCESS captures mem_read_data.
  - wb_valid pulses in DONE, 2 cycles after acceptance.
- Load extension:
  - LB: sign-extend [31:24].
  - LBU: zero-extend [31:24].
  - LH: sign-extend [31:16].
  - LHU: zero-extend [31:16].
  - LW: [31:0].
- Stores: write completes on the ACCESS negedge. DONE gives wb_valid=1, wb_we=0, wb_data=0.
- Fault conditions:
  - illegal op;
  - req_addr[31:ADDR_BITS] != 0;
  - req_addr + size - 1 > 2^ADDR_BITS - 1, with size 1/2/4 bytes.
- Fault response:
  - Skips ACCESS; code stays 0 (no write).
  - DONE gives wb_valid=1, wb_fault=1, wb_we=0, wb_data=0.
- Unaligned addresses are legal: the addresser rotates lanes.
- req_valid while not ready: ignored. Upstream holds the request until req_ready=1.
- wb_rd in DONE equals the accepted req_rd. wb_we=1 only for a non-faulted load.

Test Plan:
- Reset with resetn=0 for 2 cycles mid-ACCESS -> next cycle IDLE, req_ready=1, all outputs 0, mem_access_code=0.
- SW addr 0x100 wdata 0xDEADBEEF, then LW 0x100 rd=5 -> LW wb_valid 2 cycles after acceptance, wb_we=1, wb_rd=5, wb_data=0xDEADBEEF.
- SW 0x200 0x80FF7F01; LB 0x201 -> 0xFFFFFFFF; LBU 0x201 -> 0x000000FF; LH 0x202 -> 0x00007F01; LHU 0x200 -> 0x000080FF.
- Unaligned SH 0x303 wdata 0x0000A55A, then LW 0x300 after SW 0x300 0 -> 0x000000A5; LW 0x304 (preceded by SW 0x304 0) -> 0x5A000000.
- LW 0x3FFFD (crosses top) and op 0011 -> wb_fault=1, wb_we=0, wb_data=0, mem_access_code[4] never 1, 1-cycle latency.
- Back-to-back req_valid held high -> accept every 3 cycles, req_ready low in ACCESS/DONE, no request dropped or duplicated.
